// File: rtl/io_bus_arbiter.sv
// Round-robin arbiter muxing one of NREQ requesters onto a shared output bus.
// Optional hold limit (forced rotation) is compiled in with ARB_HOLD_LIMIT_EN.
//
// state | meaning
// IDLE  | no owner, bus undriven, waiting for a request
// GRANT | one requester owns the bus
// TURN  | one-cycle idle gap between owners
module io_bus_arbiter #(
  parameter int NREQ     = 4,
  parameter int DW       = 8,
  parameter int MAX_HOLD = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*DW-1:0]      data_in,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] owner,
  output logic [DW-1:0]           bus_out,
  output logic                    bus_oe,
  output logic                    busy
);

  localparam int OW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8 || MAX_HOLD < 2) begin : g_param_check
    $error("io_bus_arbiter: NREQ must be 2..8 and MAX_HOLD >= 2");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [OW-1:0]   ptr_q, ptr_d;
  logic [OW-1:0]   win;
  logic            found;
  logic            preempt;
  logic [OW-1:0]   owner_inc;

`ifdef ARB_HOLD_LIMIT_EN
  localparam int HW = $clog2(MAX_HOLD);
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
`endif

  // Two passes give the first requester at or after ptr, wrapping without a modulo.
  always_comb begin
    found = 1'b0;
    win   = ptr_q;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && (i >= int'(ptr_q)) && req[i]) begin
        found = 1'b1;
        win   = OW'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found && (i < int'(ptr_q)) && req[i]) begin
        found = 1'b1;
        win   = OW'(i);
      end
    end
  end

  assign owner_inc = (owner_q == OW'(NREQ - 1)) ? '0 : owner_q + 1'b1;

  always_comb begin
    preempt = 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
    preempt = (hold_cnt_q == HW'(MAX_HOLD - 1)) && (|(req & ~grant_q));
`endif
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
`ifdef ARB_HOLD_LIMIT_EN
    hold_cnt_d = hold_cnt_q;
`endif
    if (!ena) begin
      state_d = IDLE;
      grant_d = '0;
    end else begin
      case (state_q)
        IDLE, TURN: begin
          if (found) begin
            state_d = GRANT;
            grant_d = NREQ'(1) << win;
            owner_d = win;
`ifdef ARB_HOLD_LIMIT_EN
            hold_cnt_d = '0;
`endif
          end else begin
            state_d = IDLE;
            grant_d = '0;
          end
        end
        GRANT: begin
          if (!req[owner_q] || preempt) begin
            state_d = TURN;
            grant_d = '0;
            ptr_d   = owner_inc;
          end
`ifdef ARB_HOLD_LIMIT_EN
          else if (hold_cnt_q != HW'(MAX_HOLD - 1)) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
`endif
        end
        default: begin
          state_d = IDLE;
          grant_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
`ifdef ARB_HOLD_LIMIT_EN
      hold_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
`ifdef ARB_HOLD_LIMIT_EN
      hold_cnt_q <= hold_cnt_d;
`endif
    end
  end

  // Grant is one-hot, so OR-ing the selected slices is a plain mux.
  always_comb begin
    bus_out = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q[i]) begin
        bus_out = bus_out | data_in[i*DW +: DW];
      end
    end
  end

  assign grant  = grant_q;
  assign owner  = owner_q;
  assign bus_oe = |grant_q;
  assign busy   = (state_q == GRANT) || (state_q == TURN);

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Directed bench for io_bus_arbiter (NREQ=4, DW=8, MAX_HOLD=8); honours ARB_HOLD_LIMIT_EN.
module tb_io_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b1;
  logic [3:0]  req = 4'b1111;
  logic [31:0] data_in = {8'h3C, 8'hA5, 8'h5A, 8'hC3};
  logic [3:0]  grant;
  logic [1:0]  owner;
  logic [7:0]  bus_out;
  logic        bus_oe;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] slice_data [4] = '{8'hC3, 8'h5A, 8'hA5, 8'h3C};

  io_bus_arbiter #(.NREQ(4), .DW(8), .MAX_HOLD(8)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .req(req), .data_in(data_in),
    .grant(grant), .owner(owner), .bus_out(bus_out), .bus_oe(bus_oe), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] g, input logic [1:0] o,
                         input logic [7:0] d, input logic oe, input logic b);
    chk({tag, ".grant"}, 32'(grant), 32'(g));
    chk({tag, ".owner"}, 32'(owner), 32'(o));
    chk({tag, ".bus_out"}, 32'(bus_out), 32'(d));
    chk({tag, ".bus_oe"}, 32'(bus_oe), 32'(oe));
    chk({tag, ".busy"}, 32'(busy), 32'(b));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset held with all requests high
    @(negedge clk); @(negedge clk);
    chk_all("reset", 4'b0000, 2'd0, 8'h00, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk_all("first_grant", 4'b0001, 2'd0, 8'hC3, 1'b1, 1'b1);
    req = 4'b0000;
    @(negedge clk);
    chk_all("first_gap", 4'b0000, 2'd0, 8'h00, 1'b0, 1'b1);
    @(negedge clk);
    chk_all("first_idle", 4'b0000, 2'd0, 8'h00, 1'b0, 1'b0);

    // single requester, ptr=1 after owner 0 released
    req = 4'b0100;
    @(negedge clk);
    chk_all("single", 4'b0100, 2'd2, 8'hA5, 1'b1, 1'b1);
    data_in[23:16] = 8'h96;
    #1 chk("single.comb_data", 32'(bus_out), 32'h96);
    data_in[23:16] = 8'hA5;
    @(negedge clk);
    chk_all("single_hold", 4'b0100, 2'd2, 8'hA5, 1'b1, 1'b1);
    req = 4'b0000;
    @(negedge clk);
    chk_all("single_gap", 4'b0000, 2'd2, 8'h00, 1'b0, 1'b1);
    @(negedge clk);
    chk_all("single_idle", 4'b0000, 2'd2, 8'h00, 1'b0, 1'b0);

    // reset restores ptr=0 for the round-robin sequence
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req = 4'b1111;
    @(negedge clk);
    for (int o = 0; o < 5; o++) begin
      for (int c = 0; c < 3; c++) begin
        chk_all("rr_own", 4'(1 << (o % 4)), 2'(o % 4), slice_data[o % 4], 1'b1, 1'b1);
        if (c < 2) @(negedge clk);
      end
      req[o % 4] = 1'b0;
      @(negedge clk);
      chk_all("rr_gap", 4'b0000, 2'(o % 4), 8'h00, 1'b0, 1'b1);
      req[o % 4] = 1'b1;
      @(negedge clk);
    end
    chk_all("rr_next", 4'b0010, 2'd1, 8'h5A, 1'b1, 1'b1);
    req = 4'b0000;
    @(negedge clk); @(negedge clk); @(negedge clk);
    chk_all("rr_idle", 4'b0000, 2'd1, 8'h00, 1'b0, 1'b0);

    // preemption: req0 held, req1 joins in the second grant cycle
    req = 4'b0001;
    @(negedge clk);
    chk("pre.c1", 32'(grant), 32'b0001);
    req = 4'b0011;
    for (int c = 2; c <= 8; c++) begin
      @(negedge clk);
      chk("pre.hold", 32'(grant), 32'b0001);
    end
    @(negedge clk);
`ifdef ARB_HOLD_LIMIT_EN
    chk_all("pre_gap", 4'b0000, 2'd0, 8'h00, 1'b0, 1'b1);
    @(negedge clk);
    chk_all("pre_next", 4'b0010, 2'd1, 8'h5A, 1'b1, 1'b1);
`else
    for (int c = 0; c < 6; c++) begin
      chk_all("pre_nolimit", 4'b0001, 2'd0, 8'hC3, 1'b1, 1'b1);
      @(negedge clk);
    end
`endif
    req = 4'b0000;
    @(negedge clk); @(negedge clk); @(negedge clk);
    chk("pre.idle_busy", 32'(busy), 32'd0);

    // saturation: owner alone for 20 cycles, then a competitor appears
    req = 4'b0001;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("sat.hold", 32'(grant), 32'b0001);
    end
    req = 4'b1001;
    @(negedge clk);
`ifdef ARB_HOLD_LIMIT_EN
    chk_all("sat_gap", 4'b0000, 2'd0, 8'h00, 1'b0, 1'b1);
    @(negedge clk);
    chk_all("sat_next", 4'b1000, 2'd3, 8'h3C, 1'b1, 1'b1);
`else
    chk_all("sat_nolimit", 4'b0001, 2'd0, 8'hC3, 1'b1, 1'b1);
    @(negedge clk);
    chk_all("sat_nolimit2", 4'b0001, 2'd0, 8'hC3, 1'b1, 1'b1);
`endif
    req = 4'b0000;
    @(negedge clk); @(negedge clk); @(negedge clk);

    // ena low mid-grant, then async reset mid-cycle
    req = 4'b0100;
    @(negedge clk);
    chk_all("ena_grant", 4'b0100, 2'd2, 8'hA5, 1'b1, 1'b1);
    ena = 1'b0;
    @(negedge clk);
    chk_all("ena_off", 4'b0000, 2'd2, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    chk_all("ena_off2", 4'b0000, 2'd2, 8'h00, 1'b0, 1'b0);
    ena = 1'b1;
    @(negedge clk);
    chk_all("ena_back", 4'b0100, 2'd2, 8'hA5, 1'b1, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk_all("async_rst", 4'b0000, 2'd0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    req = 4'b0010;
    @(negedge clk);
    chk_all("post_rst", 4'b0010, 2'd1, 8'h5A, 1'b1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
